// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - seven-segment digit scan controller with framed value loading
// One anode low at a time with a dark gap between digits; new values land only at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int GAP        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      lz_blank,
  input  logic                      load_valid,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  output logic                      load_ready,
  output logic [3:0]                digit_num,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_done
);

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_SHOW,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            num_q, num_d;
  logic                  fd_q, fd_d;
  logic                  ready_q;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q;
  logic                  pend_flag_q, pend_flag_d;

  logic                  gap_end;
  logic                  boundary;
  logic                  commit;
  logic                  accept;
  logic [NUM_DIGITS-1:0] blank;
  logic                  show_entry;
  logic [IW-1:0]         next_idx;

  assign gap_end  = (state_q == S_GAP) && (cnt_q == GAP_LAST);
  assign boundary = enable && gap_end && (idx_q == IDX_LAST);
  // While parked there is no frame to tear, so a pending value commits immediately.
  assign commit   = pend_flag_q && (boundary || (state_q == S_OFF));
  assign accept   = load_valid && ready_q;
  assign disp_d   = commit ? pend_q : disp_q;

  assign pend_flag_d = accept ? 1'b1 : (commit ? 1'b0 : pend_flag_q);

  // Blanking looks at the value that will be on display after this edge.
  always_comb begin
    logic tail;
    blank = '0;
    tail  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail     = tail && (disp_d[4*i +: 4] == 4'h0);
      blank[i] = lz_blank && tail && (i != 0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      an_q    <= '1;
      num_q   <= 4'h0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      num_q   <= num_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    an_d       = an_q;
    num_d      = num_q;
    fd_d       = 1'b0;
    show_entry = 1'b0;
    next_idx   = idx_q;

    case (state_q)
      S_OFF: begin
        an_d  = '1;
        idx_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d    = S_SHOW;
          show_entry = 1'b1;
          next_idx   = '0;
        end
      end
      S_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          an_d    = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_d    = S_SHOW;
          cnt_d      = '0;
          next_idx   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          idx_d      = next_idx;
          show_entry = 1'b1;
          fd_d       = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_OFF;
        an_d    = '1;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (!enable) begin
      state_d    = S_OFF;
      an_d       = '1;
      idx_d      = '0;
      cnt_d      = '0;
      fd_d       = 1'b0;
      show_entry = 1'b0;
    end

    // Decoder input and anode switch together so no digit flashes the old nibble.
    if (show_entry) begin
      num_d = disp_d[4*next_idx +: 4];
      an_d  = '1;
      if (!blank[next_idx]) an_d[next_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q      <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      disp_q      <= disp_d;
      pend_flag_q <= pend_flag_d;
      ready_q     <= !pend_flag_d;
      if (accept) pend_q <= load_data;
    end
  end

  assign load_ready = ready_q;
  assign digit_num  = num_q;
  assign an_n       = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (4 digits, DWELL=4, GAP=2)
// Frame table drives a per-cycle scoreboard; hand sequences cover disable, re-enable and reset.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        lz_blank = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready;
  logic [3:0]  digit_num;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  bit pend_m = 1'b0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .GAP(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .digit_num  (digit_num),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] num;
    logic       fd;
    logic       rdy;
  } exp_t;

  // an/num hold one nibble per digit, digit 0 in the low nibble
  typedef struct packed {
    logic [15:0] an;
    logic [15:0] num;
    logic        lz;
    logic        load_en;
    logic [4:0]  load_t;
    logic [15:0] load_val;
  } frame_t;

  exp_t   sb[$];
  frame_t frames[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int k, input bit first);
    exp_t e;
    exp_t got;
    int   d;
    int   ph;
    bit   ld;
    lz_blank = frames[k].lz;
    if (first) enable = 1'b1;
    for (int t = 0; t < 24; t++) begin
      d  = t / 6;
      ph = t % 6;
      ld = 1'b0;
      if (frames[k].load_en && (t == int'(frames[k].load_t))) begin
        load_valid = 1'b1;
        load_data  = frames[k].load_val;
        ld = !pend_m;
      end
      if (ld) pend_m = 1'b1;
      else if (t == 0 && !first) pend_m = 1'b0;
      e.an  = (ph < 4) ? frames[k].an[4*d +: 4] : 4'hF;
      e.num = frames[k].num[4*d +: 4];
      e.fd  = (t == 0) && !first;
      e.rdy = !pend_m;
      sb.push_back(e);
      tick();
      load_valid = 1'b0;
      got = sb.pop_front();
      chk($sformatf("f%0d_t%0d_an", k, t), {12'h0, an_n}, {12'h0, got.an});
      chk($sformatf("f%0d_t%0d_num", k, t), {12'h0, digit_num}, {12'h0, got.num});
      chk($sformatf("f%0d_t%0d_fd", k, t), {15'h0, frame_done}, {15'h0, got.fd});
      chk($sformatf("f%0d_t%0d_rdy", k, t), {15'h0, load_ready}, {15'h0, got.rdy});
    end
  endtask

  initial begin
    frames[0] = '{an:16'h7BDE, num:16'h12A0, lz:1'b0, load_en:1'b1, load_t:5'd5, load_val:16'h0005};
    frames[1] = '{an:16'h7BDE, num:16'h0005, lz:1'b0, load_en:1'b1, load_t:5'd5, load_val:16'h0005};
    frames[2] = '{an:16'hFFFE, num:16'h0005, lz:1'b1, load_en:1'b1, load_t:5'd5, load_val:16'h0000};
    frames[3] = '{an:16'hFFFE, num:16'h0000, lz:1'b1, load_en:1'b1, load_t:5'd5, load_val:16'h0100};
    frames[4] = '{an:16'hFBDE, num:16'h0100, lz:1'b1, load_en:1'b0, load_t:5'd0, load_val:16'h0000};
    frames[5] = '{an:16'hFBDE, num:16'h0100, lz:1'b1, load_en:1'b1, load_t:5'd0, load_val:16'h12A0};
    frames[6] = '{an:16'h7BDE, num:16'h12A0, lz:1'b1, load_en:1'b0, load_t:5'd0, load_val:16'h0000};

    // reset takes effect without a clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an", {12'h0, an_n}, 16'h000F);
    chk("rst_num", {12'h0, digit_num}, 16'h0000);
    chk("rst_rdy", {15'h0, load_ready}, 16'h0001);
    chk("rst_fd", {15'h0, frame_done}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // load while parked: accepted, then committed on the following cycle
    load_valid = 1'b1;
    load_data  = 16'h12A0;
    tick();
    load_valid = 1'b0;
    chk("off_load_rdy0", {15'h0, load_ready}, 16'h0000);
    tick();
    chk("off_commit_rdy1", {15'h0, load_ready}, 16'h0001);
    chk("off_an", {12'h0, an_n}, 16'h000F);

    for (int k = 0; k < 7; k++) run_frame(k, k == 0);

    // disable during digit 2 of the next frame, with a load in the same cycle
    for (int t = 0; t < 13; t++) tick();
    chk("d2_an", {12'h0, an_n}, 16'h000B);
    chk("d2_num", {12'h0, digit_num}, 16'h0002);
    enable     = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h0007;
    tick();
    load_valid = 1'b0;
    chk("dis_an", {12'h0, an_n}, 16'h000F);
    chk("dis_rdy0", {15'h0, load_ready}, 16'h0000);
    tick();
    chk("dis_commit_rdy1", {15'h0, load_ready}, 16'h0001);
    chk("dis_an2", {12'h0, an_n}, 16'h000F);
    lz_blank = 1'b0;
    enable   = 1'b1;
    tick();
    chk("reen_an", {12'h0, an_n}, 16'h000E);
    chk("reen_num", {12'h0, digit_num}, 16'h0007);
    chk("reen_fd", {15'h0, frame_done}, 16'h0000);

    // take a value mid-frame, then reset during the gap
    load_valid = 1'b1;
    load_data  = 16'h0009;
    tick();
    load_valid = 1'b0;
    chk("pend_rdy0", {15'h0, load_ready}, 16'h0000);
    for (int t = 2; t < 4; t++) begin
      tick();
      chk($sformatf("reen_t%0d_an", t), {12'h0, an_n}, 16'h000E);
      chk($sformatf("reen_t%0d_fd", t), {15'h0, frame_done}, 16'h0000);
    end
    tick();
    chk("gap_an", {12'h0, an_n}, 16'h000F);
    chk("gap_num", {12'h0, digit_num}, 16'h0007);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_an", {12'h0, an_n}, 16'h000F);
    chk("rst2_num", {12'h0, digit_num}, 16'h0000);
    chk("rst2_rdy", {15'h0, load_ready}, 16'h0001);
    chk("rst2_fd", {15'h0, frame_done}, 16'h0000);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_an", {12'h0, an_n}, 16'h000E);
    chk("post_rst_num", {12'h0, digit_num}, 16'h0000);
    chk("post_rst_rdy", {15'h0, load_ready}, 16'h0001);
    chk("post_rst_fd", {15'h0, frame_done}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
